// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures div_clk periods in clk_in cycles and reports lock, errors, timeout.
// Optional duty-cycle check is compiled in with `define CLK_DIV_MON_DUTY_EN.
`timescale 1ns/1ps

module clk_div_monitor #(
  parameter int DIV_RATIO  = 32,
  parameter int TOL        = 0,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic             timeout,
  output logic             duty_err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(2 * DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(DIV_RATIO - TOL);
  localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(DIV_RATIO + TOL);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_COUNT - 1);

  // Synchronizer and edge detector; rise_q lags a div_clk rise by 3 clk_in cycles.
  logic s1_q, s2_q, prev_q, rise_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= div_clk;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= s2_q & ~prev_q;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic [7:0]       ecnt_base;
  logic             timeout_q, timeout_d;
  logic [GW-1:0]    good_q, good_d;
  logic             period_good;
  logic             new_err;

  assign period_good = (cnt_q >= PER_LO) && (cnt_q <= PER_HI);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    good_d    = good_q;
    new_err   = 1'b0;
    // clr is applied first so a coincident new error still lands on top of it.
    err_d     = clr ? 1'b0 : err_q;
    ecnt_base = clr ? 8'd0 : ecnt_q;

    if (rise_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if (rise_q) begin
      timeout_d = 1'b0;
      case (state_q)
        SEARCH: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!period_good) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            good_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!period_good) begin
            new_err  = 1'b1;
            locked_d = 1'b0;
            state_d  = ACQUIRE;
            good_d   = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end else if (cnt_q == TO_LAST) begin
      // cnt is about to reach 2*DIV_RATIO with no rise: the clock is gone.
      state_d   = SEARCH;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      good_d    = '0;
      new_err   = (state_q == LOCKED);
    end

    ecnt_d = ecnt_base;
    if (new_err) begin
      err_d = 1'b1;
      if (ecnt_base != 8'hFF) begin
        ecnt_d = ecnt_base + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= SEARCH;
      cnt_q     <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      ecnt_q    <= 8'd0;
      timeout_q <= 1'b0;
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      ecnt_q    <= ecnt_d;
      timeout_q <= timeout_d;
      good_q    <= good_d;
    end
  end

`ifdef CLK_DIV_MON_DUTY_EN
  localparam logic [CNT_W-1:0] HIGH_LO = CNT_W'(DIV_RATIO / 2 - TOL);
  localparam logic [CNT_W-1:0] HIGH_HI = CNT_W'(DIV_RATIO / 2 + TOL);

  logic             fall_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             duty_q, duty_d;

  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    duty_d = clr ? 1'b0 : duty_q;
    if (s2_q) begin
      if (!prev_q) begin
        hcnt_d = CNT_W'(1);
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    // hcnt holds while low, so the fall pulse sees the full high count.
    if (fall_q) begin
      high_d = hcnt_q;
      if ((state_q == LOCKED) && ((hcnt_q < HIGH_LO) || (hcnt_q > HIGH_HI))) begin
        duty_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      fall_q <= 1'b0;
      hcnt_q <= '0;
      high_q <= '0;
      duty_q <= 1'b0;
    end else begin
      fall_q <= ~s2_q & prev_q;
      hcnt_q <= hcnt_d;
      high_q <= high_d;
      duty_q <= duty_d;
    end
  end

  assign high_time = high_q;
  assign duty_err  = duty_q;
`else
  assign high_time = '0;
  assign duty_err  = 1'b0;
`endif

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_cnt    = ecnt_q;
  assign timeout    = timeout_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: period-level reference model feeding an expected queue,
// checked on every period_vld, plus direct checks for timeout, clear and reset.
`timescale 1ns/1ps

module tb_clk_div_monitor;

  localparam int DIV  = 32;
  localparam int TOL  = 0;
  localparam int LOCK = 4;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       div_clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] period;
  logic       period_vld;
  logic [7:0] high_time;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic       timeout;
  logic       duty_err;
  logic [1:0] state_o;

  clk_div_monitor #(
    .DIV_RATIO (DIV),
    .TOL       (TOL),
    .CNT_W     (8),
    .LOCK_COUNT(LOCK)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk   (div_clk),
    .clr       (clr),
    .period    (period),
    .period_vld(period_vld),
    .high_time (high_time),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .timeout   (timeout),
    .duty_err  (duty_err),
    .state_o   (state_o)
  );

  // clock / reset
  always #100 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // {period[7:0], locked, err, err_cnt[7:0]}
  logic [17:0] exp_q[$];

  int m_state = 0;  // 0 search, 1 acquire, 2 locked
  int m_good  = 0;
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;
  int m_ecnt   = 0;
  int last_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_good   = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_ecnt   = 0;
    last_len = 0;
    exp_q.delete();
  endtask

  // A new div_clk rise closes the period of length last_len.
  task automatic model_rise(input bit clr_now);
    bit good;
    good = (last_len >= DIV - TOL) && (last_len <= DIV + TOL);
    if (clr_now) begin
      m_err  = 1'b0;
      m_ecnt = 0;
    end
    if (m_state == 0) begin
      m_state = 1;
      m_good  = 0;
    end else begin
      if (m_state == 1) begin
        if (!good) m_good = 0;
        else begin
          m_good++;
          if (m_good == LOCK) begin
            m_state  = 2;
            m_locked = 1'b1;
            m_good   = 0;
          end
        end
      end else if (!good) begin
        m_err    = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
        m_locked = 1'b0;
        m_state  = 1;
        m_good   = 0;
      end
      exp_q.push_back({8'(last_len), m_locked, m_err, 8'(m_ecnt)});
    end
  endtask

  // driver: one div_clk period starting with a rise at the current negedge
  task automatic drive_period(input int h, input int l, input bit do_clr);
    model_rise(do_clr);
    for (int i = 0; i < h + l; i++) begin
      div_clk = (i < h);
      clr     = do_clr && (i == 3);
      @(negedge clk_in);
    end
    clr      = 1'b0;
    last_len = h + l;
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  // scoreboard
  always @(negedge clk_in) begin
    if (rst && period_vld) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty_at_vld", exp_q.size(), 1);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check_eq("period", period, e[17:10]);
        check_eq("locked_at_vld", locked, e[9]);
        check_eq("err_at_vld", err, e[8]);
        check_eq("err_cnt_at_vld", err_cnt, e[7:0]);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check_eq("rst_period", period, 0);
    check_eq("rst_vld", period_vld, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_high_time", high_time, 0);
    check_eq("rst_duty_err", duty_err, 0);
    check_eq("rst_state", state_o, 0);
    rst = 1'b1;
    model_reset();

    // divide-by-32 acquires lock on the 5th rise
    repeat (5) drive_period(16, 16, 1'b0);
    check_eq("s1_locked", locked, 1);
    check_eq("s1_err", err, 0);

    // one short period while locked, then relock
    drive_period(16, 15, 1'b0);
    repeat (5) drive_period(16, 16, 1'b0);
    check_eq("s2_locked", locked, 1);
    check_eq("s2_err", err, 1);
    check_eq("s2_err_cnt", err_cnt, 1);

    // clock stops low: timeout 64 cycles after the rise pulse
    drive_period(16, 50, 1'b0);
    check_eq("s3_timeout_early", timeout, 0);
    @(negedge clk_in);
    if (m_state == 2) begin
      m_err = 1'b1;
      if (m_ecnt < 255) m_ecnt++;
    end
    m_state  = 0;
    m_locked = 1'b0;
    m_good   = 0;
    check_eq("s3_timeout", timeout, 1);
    check_eq("s3_locked", locked, 0);
    check_eq("s3_err", err, m_err);
    check_eq("s3_err_cnt", err_cnt, m_ecnt);
    check_eq("s3_state", state_o, 0);
    drive_period(16, 16, 1'b0);
    check_eq("s3_timeout_clear", timeout, 0);
    repeat (4) drive_period(16, 16, 1'b0);
    check_eq("s3_relocked", locked, 1);

    // clr coincides with a bad-period detection
    drive_period(16, 15, 1'b0);
    drive_period(16, 16, 1'b1);
    check_eq("s4_err", err, 1);
    check_eq("s4_err_cnt", err_cnt, 1);
    check_eq("s4_locked", locked, 0);
    repeat (4) drive_period(16, 16, 1'b0);
    check_eq("s4_relocked", locked, 1);

    // asynchronous reset between clock edges
    #50;
    rst = 1'b0;
    div_clk = 1'b0;
    #1;
    check_eq("s5_locked", locked, 0);
    check_eq("s5_err", err, 0);
    check_eq("s5_period", period, 0);
    check_eq("s5_err_cnt", err_cnt, 0);
    check_eq("s5_timeout", timeout, 0);
    check_eq("s5_state", state_o, 0);
    model_reset();
    @(negedge clk_in);
    rst = 1'b1;

    // 20-high / 12-low clock
    repeat (7) drive_period(20, 12, 1'b0);
    check_eq("s6_locked", locked, 1);
`ifdef CLK_DIV_MON_DUTY_EN
    check_eq("s6_high_time", high_time, 20);
    check_eq("s6_duty_err", duty_err, 1);
`else
    check_eq("s6_high_time", high_time, 0);
    check_eq("s6_duty_err", duty_err, 0);
`endif
    check_eq("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
